mem_test_sequencer: RTL and testbench

- Upstream traffic generator for the async cellular-RAM controller: on `start` it writes a deterministic pattern to every word in a small address window, then reads each word back and compares it.
- Reports pass/fail, a saturating error count and the first failing address, for the board display path.
- Drives one request at a time over a level req/ack handshake; never issues overlapping transactions.

---
 rtl/mem_test_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_mem_test_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_sequencer.sv
// Memory self-test sequencer: writes a seeded nibble pattern across a small address window, then
// reads it back and reports pass/fail. Define MEMTEST_TIMEOUT_EN to add a per-request ack timeout.
module mem_test_sequencer #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        seed,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr
`ifdef MEMTEST_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  if ((DATA_W % 4) != 0 || DATA_W == 0 || TIMEOUT == 0) begin : g_bad_params
    $error("mem_test_sequencer: DATA_W must be a nonzero multiple of 4 and TIMEOUT nonzero");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWgap,
    StRead,
    StRgap,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] AddrLast = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        seed_q, seed_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [7:0]        err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;

  logic [3:0]        nibble;
  logic [DATA_W-1:0] pattern;

`ifdef MEMTEST_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Only the low nibble of the address feeds the pattern; narrower windows zero-extend.
  assign nibble  = seed_q + 4'(addr_q);
  assign pattern = {(DATA_W / 4){nibble}};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    seed_d  = seed_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
`ifdef MEMTEST_TIMEOUT_EN
    tmo_cnt_d = '0;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWrite;
          addr_d  = '0;
          we_d    = 1'b1;
          seed_d  = seed;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 8'd0;
          first_d = '0;
`ifdef MEMTEST_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StWrite: begin
        if (mem_ack) state_d = StWgap;
      end
      StWgap: begin
        if (addr_q == AddrLast) begin
          state_d = StRead;
          addr_d  = '0;
          we_d    = 1'b0;
        end else begin
          state_d = StWrite;
          addr_d  = addr_q + 1'b1;
        end
      end
      StRead: begin
        if (mem_ack) begin
          state_d = StRgap;
          if (mem_rdata != pattern) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (err_q == 8'd0) first_d = addr_q;
          end
        end
      end
      StRgap: begin
        if (addr_q == AddrLast) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_q == 8'd0);
        end else begin
          state_d = StRead;
          addr_d  = addr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef MEMTEST_TIMEOUT_EN
    // Counter runs only while a request is outstanding; gaps and idle keep it cleared.
    if ((state_q == StWrite || state_q == StRead) && !mem_ack) begin
      if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
        state_d   = StDone;
        we_d      = 1'b0;
        done_d    = 1'b1;
        pass_d    = 1'b0;
        timeout_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      seed_q  <= 4'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      seed_q  <= seed_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

`ifdef MEMTEST_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  // Request decodes straight from the state register so an async reset drops it at once.
  assign mem_req        = (state_q == StWrite) || (state_q == StRead);
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = we_q ? pattern : '0;
  assign busy           = state_q inside {StWrite, StWgap, StRead, StRgap};
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Scoreboard bench for mem_test_sequencer: random runs against a behavioural memory model, plus
// reset, restart, saturation (512-word instance) and, with MEMTEST_TIMEOUT_EN, ack-timeout cases.
`timescale 1ns/1ps
module tb_mem_test_sequencer;

  localparam int AW  = 3;
  localparam int N   = 8;
  localparam int DW  = 16;
  localparam int BAW = 9;
  localparam int BN  = 512;
  localparam int TMO = 63;

  typedef struct {
    bit we;
    int addr;
    int wdata;
  } txn_t;

  typedef struct {
    bit pass;
    int errs;
    int first;
    int cycles;
    bit tmo;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, start_b;
  logic [3:0]    seed, seed_b;
  logic          mem_req, mem_we, mem_ack, busy, done, pass;
  logic [AW-1:0] mem_addr, first_err_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [7:0]    err_count;
  logic           b_req, b_we, b_ack, b_busy, b_done, b_pass;
  logic [BAW-1:0] b_addr, b_first;
  logic [DW-1:0]  b_wdata, b_rdata;
  logic [7:0]     b_err;
`ifdef MEMTEST_TIMEOUT_EN
  logic timeout, b_timeout;
`endif

  mem_test_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
`ifdef MEMTEST_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  mem_test_sequencer #(.ADDR_W(BAW), .DATA_W(DW), .TIMEOUT(TMO)) dut_big (
    .clk(clk), .reset_n(reset_n), .start(start_b), .seed(seed_b),
    .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_ack(b_ack), .mem_rdata(b_rdata), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .first_err_addr(b_first)
`ifdef MEMTEST_TIMEOUT_EN
    , .timeout(b_timeout)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference pattern: every nibble is (seed + address) mod 16.
  function automatic logic [DW-1:0] pattern(input logic [3:0] s, input int a);
    logic [DW-1:0] v = '0;
    int nib = (int'(s) + a) % 16;
    for (int i = 0; i < DW / 4; i++) v = (v << 4) | DW'(nib);
    return v;
  endfunction

  // ---------------- memory models ----------------
  int          k_lat = 1;
  logic [N-1:0] stuck_mask = '0;
  int          no_ack_addr = -1;
  bit          stray = 1'b0;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] bmem [BN];
  logic        resp_ack = 1'b0;
  logic        b_resp = 1'b0;
  int          rcnt = 0;

  assign mem_ack = resp_ack | stray;
  assign b_ack   = b_resp;

  initial begin
    mem_rdata = '0;
    b_rdata   = '0;
  end

  // Acks in the k_lat-th cycle of a request; stuck_mask forces read bit 0 high.
  always @(negedge clk) begin
    if (!reset_n || !mem_req || resp_ack) begin
      resp_ack = 1'b0;
      rcnt     = 0;
    end else begin
      rcnt++;
      if (rcnt == k_lat && !(mem_we && int'(mem_addr) == no_ack_addr)) begin
        resp_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else begin
          mem_rdata = mem[mem_addr];
          if (stuck_mask[mem_addr]) mem_rdata[0] = 1'b1;
        end
      end
    end
  end

  // Large window: single-cycle ack, every read returned inverted.
  always @(negedge clk) begin
    if (!reset_n || !b_req || b_resp) b_resp = 1'b0;
    else begin
      b_resp = 1'b1;
      if (b_we) bmem[b_addr] = b_wdata;
      else b_rdata = ~bmem[b_addr];
    end
  end

  // ---------------- scoreboard ----------------
  txn_t txn_q[$];
  res_t res_q[$];
  res_t res_b_q[$];

  task automatic expect_run(input logic [3:0] s, input int k, input logic [N-1:0] stuck,
                            input int noack);
    int errs = 0;
    int first = 0;
    logic [DW-1:0] p, rd;
    for (int a = 0; a < N; a++) begin
      txn_q.push_back('{1'b1, a, int'(pattern(s, a))});
      if (a == noack) begin
        res_q.push_back('{1'b0, 0, 0, -1, 1'b1});
        return;
      end
    end
    for (int a = 0; a < N; a++) begin
      txn_q.push_back('{1'b0, a, 0});
      p  = pattern(s, a);
      rd = stuck[a] ? (p | DW'(1)) : p;  // stuck-at-1 is only visible where the bit is 0
      if (rd != p) begin
        if (errs == 0) first = a;
        if (errs < 255) errs++;
      end
    end
    res_q.push_back('{errs == 0, errs, first, 2 * N * (k + 1), 1'b0});
  endtask

  task automatic expect_big(input logic [3:0] s);
    int errs = 0;
    for (int a = 0; a < BN; a++)
      if (~pattern(s, a) != pattern(s, a) && errs < 255) errs++;
    res_b_q.push_back('{errs == 0, errs, 0, 2 * BN * 2, 1'b0});
  endtask

  int   cyc = 0;
  int   t0 = 0;
  int   bt0 = 0;
  bit   req_prev = 1'b0;
  bit   done_prev = 1'b0;
  bit   bdone_prev = 1'b0;
  bit   breq_prev = 1'b0;
  txn_t cur_t;
  res_t cur_r;
  res_t cur_b;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      req_prev   = 1'b0;
      done_prev  = 1'b0;
      breq_prev  = 1'b0;
      bdone_prev = 1'b0;
    end else begin
      if (mem_req && !req_prev) begin
        if (txn_q.size() == 0) fail("unexpected request");
        else begin
          cur_t = txn_q.pop_front();
          check("req we", mem_we, cur_t.we);
          check("req addr", mem_addr, cur_t.addr);
          check("req wdata", mem_wdata, cur_t.wdata);
          if (cur_t.we && cur_t.addr == 0) t0 = cyc;
        end
      end else if (mem_req) begin
        check("held wdata", mem_wdata, cur_t.wdata);
        check("held addr", mem_addr, cur_t.addr);
      end
      req_prev = mem_req;
      if (done && !done_prev) begin
        if (res_q.size() == 0) fail("unexpected done");
        else begin
          cur_r = res_q.pop_front();
          check("pass", pass, cur_r.pass);
          check("err_count", err_count, cur_r.errs);
          check("first_err_addr", first_err_addr, cur_r.first);
          check("busy at done", busy, 0);
          if (cur_r.cycles >= 0) check("run cycles", cyc - t0, cur_r.cycles);
`ifdef MEMTEST_TIMEOUT_EN
          check("timeout flag", timeout, cur_r.tmo);
`endif
        end
      end
      done_prev = done;
      if (b_req && !breq_prev && b_we && b_addr == 0) bt0 = cyc;
      breq_prev = b_req;
      if (b_done && !bdone_prev) begin
        if (res_b_q.size() == 0) fail("unexpected big done");
        else begin
          cur_b = res_b_q.pop_front();
          check("big pass", b_pass, cur_b.pass);
          check("big err_count", b_err, cur_b.errs);
          check("big first_err_addr", b_first, cur_b.first);
          check("big run cycles", cyc - bt0, cur_b.cycles);
        end
      end
      bdone_prev = b_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input logic [3:0] s);
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int i = 0;
    while ((res_q.size() != 0 || res_b_q.size() != 0 || txn_q.size() != 0) && i < limit) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    check("run completed in budget", res_q.size() + res_b_q.size() + txn_q.size(), 0);
  endtask

  initial begin
    logic [3:0] s;
    int k, n;
    reset_n = 1'b0;
    start   = 1'b0;
    seed    = 4'h0;
    start_b = 1'b0;
    seed_b  = 4'h0;
    repeat (3) @(negedge clk);
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst err_count", err_count, 0);
    check("rst first_err_addr", first_err_addr, 0);
    check("rst big mem_req", b_req, 0);
    check("rst big busy", b_busy, 0);
    reset_n = 1'b1;

    // Ideal memory, seed 3, K=6.
    k_lat = 6;
    stuck_mask = '0;
    expect_run(4'h3, 6, '0, -1);
    pulse_start(4'h3);
    wait_drain(400);

    // Stray ack while DONE must not disturb the result.
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    check("done held after stray ack", done, 1);
    check("pass held after stray ack", pass, 1);

    // Bit 0 stuck-at-1 on addresses 2 and 5, seed 0.
    k_lat = int'($urandom_range(1, 4));
    stuck_mask = 8'b0010_0100;
    expect_run(4'h0, k_lat, stuck_mask, -1);
    pulse_start(4'h0);
    wait_drain(300);

    // Random runs.
    for (int r = 0; r < 4; r++) begin
      s = 4'($urandom);
      k_lat = int'($urandom_range(1, 5));
      stuck_mask = N'($urandom);
      expect_run(s, k_lat, stuck_mask, -1);
      pulse_start(s);
      wait_drain(300);
    end

    // Start pulses mid-run are ignored; a start from DONE restarts with the new seed.
    k_lat = 2;
    stuck_mask = 8'b1000_0001;
    expect_run(4'h5, 2, stuck_mask, -1);
    pulse_start(4'h5);
    for (int p = 0; p < 4; p++) begin
      repeat (7) @(negedge clk);
      check("busy mid-run", busy, 1);
      start = 1'b1;
      seed  = 4'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    wait_drain(200);
    stuck_mask = '0;
    expect_run(4'hF, 2, '0, -1);
    pulse_start(4'hF);
    check("done cleared on restart", done, 0);
    check("err cleared on restart", err_count, 0);
    check("restart addr0 wdata", mem_wdata, pattern(4'hF, 0));
    wait_drain(200);

    // Async reset during a read with the request high.
    k_lat = 3;
    expect_run(4'h9, 3, '0, -1);
    pulse_start(4'h9);
    n = 0;
    while (!(mem_req && !mem_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached read phase", mem_req && !mem_we, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid-read rst mem_req", mem_req, 0);
    check("mid-read rst mem_we", mem_we, 0);
    check("mid-read rst mem_addr", mem_addr, 0);
    check("mid-read rst mem_wdata", mem_wdata, 0);
    check("mid-read rst busy", busy, 0);
    check("mid-read rst done", done, 0);
    check("mid-read rst err_count", err_count, 0);
    res_q.delete();
    txn_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    check("stray ack mem_req", mem_req, 0);
    check("stray ack busy", busy, 0);
    check("stray ack done", done, 0);

    // 512-word window with every read corrupted.
    expect_big(4'h6);
    @(negedge clk);
    start_b = 1'b1;
    seed_b  = 4'h6;
    @(negedge clk);
    start_b = 1'b0;
    wait_drain(2300);

`ifdef MEMTEST_TIMEOUT_EN
    // Write at address 4 never acked.
    k_lat = 2;
    no_ack_addr = 4;
    expect_run(4'hC, 2, '0, 4);
    pulse_start(4'hC);
    n = 0;
    while (!(mem_req && mem_we && mem_addr == 3'd4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached unacked write", mem_req && mem_we && mem_addr == 3'd4, 1);
    k = 0;
    while (mem_req && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout req-high cycles", k, TMO);
    wait_drain(50);
    no_ack_addr = -1;
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
